// File: rtl/core_lsu_if.sv
// Bundle of the EXECUTE request, WRITEBACK response and memory-port signals of core_lsu.
// The slave modport is the load/store unit itself. The master modport is its environment,
// i.e. EXECUTE, WRITEBACK and the memory taken together.
interface core_lsu_if #(
   parameter int unsigned XLEN = 32
) ();
   // EXECUTE -> LSU request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [4:0]        req_rd;
   // LSU -> WRITEBACK response
   logic              rsp_valid;
   logic [XLEN-1:0]   rsp_data;
   logic [4:0]        rsp_rd;
   logic              rsp_err;
   logic [1:0]        rsp_err_code;
   // LSU <-> memory
   logic              mem_req;
   logic              mem_we;
   logic [XLEN/8-1:0] mem_be;
   logic [XLEN-1:0]   mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_ack;
   logic              mem_err;
   logic [XLEN-1:0]   mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      input  mem_ack, mem_err, mem_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err, rsp_err_code,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
      output mem_ack, mem_err, mem_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err, rsp_err_code,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: one request at a time, wait-state tolerant req/ack memory port with
// byte enables and lane replication, sign/zero-extended load return, misaligned/bus-error/
// timeout reporting. XLEN must be 32 or 64. TIMEOUT = 0 disables the ack timeout.
// Optional feature macro CORE_LSU_MISALIGN_TRAP_EN: when defined, misaligned or illegal-size
// requests complete with error code 1 and no memory cycle. When undefined, they are issued
// to the aligned address starting at lane 0.
module core_lsu #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input logic       clk,
   input logic       rst,
   core_lsu_if.slave bus
);
   localparam int unsigned NB   = XLEN / 8;
   localparam int unsigned OB   = $clog2(NB);
   localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          IS32 = (XLEN == 32);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e          state_q, state_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [4:0]      rd_q, rd_d;
   logic [OB-1:0]   off_q, off_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic [4:0]      rsp_rd_q, rsp_rd_d;
   logic            rsp_err_q, rsp_err_d;
   logic [1:0]      rsp_code_q, rsp_code_d;

   logic [1:0]      eff_size;
   logic            mis_align;
   logic [NB-1:0]   be_mask;
   logic [XLEN-1:0] wdata_rep;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep;
   logic            sbit;
   logic [XLEN-1:0] load_ext;
   logic            expire;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
   logic            illegal;
`endif

   // Size actually used for the access, and natural-alignment check of the incoming request
   always_comb begin
      eff_size = (IS32 && bus.req_size == 2'd3) ? 2'd2 : bus.req_size;
      unique case (eff_size)
         2'd0:    mis_align = 1'b0;
         2'd1:    mis_align = bus.req_addr[0];
         2'd2:    mis_align = |bus.req_addr[1:0];
         default: mis_align = |bus.req_addr[2:0];
      endcase
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      illegal = IS32 && (bus.req_size == 2'd3);
`endif
   end

   // Lane steering: byte-enable mask, store replication, load extraction and extension
   always_comb begin
      unique case (size_q)
         2'd0: begin
            be_mask   = NB'(1);
            wdata_rep = {NB{wdata_q[7:0]}};
         end
         2'd1: begin
            be_mask   = NB'(3);
            wdata_rep = {(NB/2){wdata_q[15:0]}};
         end
         2'd2: begin
            be_mask   = NB'(15);
            wdata_rep = {(NB/4){wdata_q[31:0]}};
         end
         default: begin
            be_mask   = '1;
            wdata_rep = wdata_q;
         end
      endcase
      shifted = bus.mem_rdata >> {off_q, 3'b000};
      unique case (size_q)
         2'd0: begin
            keep = XLEN'(8'hFF);
            sbit = shifted[7];
         end
         2'd1: begin
            keep = XLEN'(16'hFFFF);
            sbit = shifted[15];
         end
         2'd2: begin
            keep = XLEN'(32'hFFFF_FFFF);
            sbit = shifted[31];
         end
         default: begin
            keep = '1;
            sbit = shifted[XLEN-1];
         end
      endcase
      load_ext = shifted & keep;
      if (!uns_q && sbit) begin
         load_ext = load_ext | ~keep;
      end
   end

   // Ack wins over a same-cycle expiry because the ack branch is checked first below
   assign expire = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

   // Next-state and request/response capture
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      off_d      = off_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_rd_d   = rsp_rd_q;
      rsp_err_d  = rsp_err_q;
      rsp_code_d = rsp_code_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               size_d  = eff_size;
               uns_d   = bus.req_unsigned;
               addr_d  = {bus.req_addr[XLEN-1:OB], OB'(0)};
               wdata_d = bus.req_wdata;
               rd_d    = bus.req_rd;
               cnt_d   = '0;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
               off_d = bus.req_addr[OB-1:0];
               if (mis_align || illegal) begin
                  state_d    = StResp;
                  rsp_data_d = '0;
                  rsp_rd_d   = '0;
                  rsp_err_d  = 1'b1;
                  rsp_code_d = 2'd1;
               end else begin
                  state_d = StAccess;
               end
`else
               // Misaligned requests are issued unchecked at the aligned address, lane 0
               off_d   = mis_align ? '0 : bus.req_addr[OB-1:0];
               state_d = StAccess;
`endif
            end
         end
         StAccess: begin
            if (bus.mem_ack) begin
               state_d = StResp;
               if (bus.mem_err) begin
                  rsp_data_d = '0;
                  rsp_rd_d   = '0;
                  rsp_err_d  = 1'b1;
                  rsp_code_d = 2'd2;
               end else begin
                  rsp_data_d = we_q ? '0 : load_ext;
                  rsp_rd_d   = we_q ? 5'd0 : rd_q;
                  rsp_err_d  = 1'b0;
                  rsp_code_d = 2'd0;
               end
            end else if (expire) begin
               state_d    = StResp;
               rsp_data_d = '0;
               rsp_rd_d   = '0;
               rsp_err_d  = 1'b1;
               rsp_code_d = 2'd3;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         size_q     <= 2'd0;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 5'd0;
         off_q      <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_rd_q   <= 5'd0;
         rsp_err_q  <= 1'b0;
         rsp_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         off_q      <= off_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_rd_q   <= rsp_rd_d;
         rsp_err_q  <= rsp_err_d;
         rsp_code_q <= rsp_code_d;
      end
   end

   // Port outputs; memory-side fields read as zero outside ACCESS
   always_comb begin
      bus.req_ready    = (state_q == StIdle);
      bus.rsp_valid    = (state_q == StResp);
      bus.rsp_data     = rsp_data_q;
      bus.rsp_rd       = rsp_rd_q;
      bus.rsp_err      = rsp_err_q;
      bus.rsp_err_code = rsp_code_q;
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_be       = '0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      if (state_q == StAccess) begin
         bus.mem_req   = 1'b1;
         bus.mem_we    = we_q;
         bus.mem_be    = be_mask << off_q;
         bus.mem_addr  = addr_q;
         bus.mem_wdata = wdata_rep;
      end
   end
endmodule

// File: tb/tb_core_lsu.sv
// Bench for core_lsu at XLEN=32, TIMEOUT=4. Directed requests push their expected response
// into a queue; a monitor pops and compares on every response pulse.
module tb_core_lsu;
   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        err;
      logic [1:0]  code;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   rsp_t exp_q[$];

   core_lsu_if #(.XLEN(32)) bus ();

   core_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   // Response monitor: every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response");
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("rsp_code", 32'(bus.rsp_err_code), 32'(e.code));
         end
      end
   end

   task automatic run_req(input string nm, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int ack_after, input logic merr,
                          input logic [31:0] rdata, input logic [3:0] x_be,
                          input logic [31:0] x_addr, input logic [31:0] x_wdata,
                          input int x_nreq, input rsp_t x_rsp);
      int   guard;
      int   nreq;
      int   ack_at;
      logic done;
      @(posedge clk);
      #1;
      guard = 0;
      while (!bus.req_ready && guard < 10) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk({nm, "_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_rd       = rd;
      exp_q.push_back(x_rsp);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      nreq   = 0;
      ack_at = -1;
      done   = 1'b0;
      guard  = 0;
      while (!done && guard < 30) begin
         @(negedge clk);
         guard++;
         if (guard == 1) begin
            chk({nm, "_mem_req_first"}, 32'(bus.mem_req), 32'(x_nreq > 0));
            chk({nm, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
         end
         if (bus.rsp_valid) begin
            done = 1'b1;
            chk({nm, "_mem_req_in_rsp"}, 32'(bus.mem_req), 32'd0);
            if (ack_at >= 0) chk({nm, "_ack_latency"}, 32'(guard), 32'(ack_at + 1));
         end else if (bus.mem_req) begin
            nreq++;
            chk({nm, "_be"}, 32'(bus.mem_be), 32'(x_be));
            chk({nm, "_addr"}, bus.mem_addr, x_addr);
            chk({nm, "_we"}, 32'(bus.mem_we), 32'(we));
            chk({nm, "_wdata"}, bus.mem_wdata, x_wdata);
            if (ack_after >= 0 && nreq == ack_after + 1) begin
               bus.mem_ack   = 1'b1;
               bus.mem_err   = merr;
               bus.mem_rdata = rdata;
               ack_at = guard;
               @(posedge clk);
               #1;
               bus.mem_ack   = 1'b0;
               bus.mem_err   = 1'b0;
               bus.mem_rdata = '0;
            end
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_rsp_timeout: got no response in 30 cycles, expected one", nm);
      end
      chk({nm, "_nreq"}, 32'(nreq), 32'(x_nreq));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.req_rd       = 5'd0;
      bus.mem_ack      = 1'b0;
      bus.mem_err      = 1'b0;
      bus.mem_rdata    = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_rsp_code", 32'(bus.rsp_err_code), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      //      name       we    sz    u     addr   wdata         rd  ack mer rdata
      //      be      addr   wdata         nreq  {data, rd, err, code}
      run_req("lw", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd5, 2, 1'b0, 32'hDEADBEEF,
              4'b1111, 32'h104, 32'h0, 3, '{32'hDEADBEEF, 5'd5, 1'b0, 2'd0});
      run_req("lb", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd6, 0, 1'b0, 32'h80000000,
              4'b1000, 32'h100, 32'h0, 1, '{32'hFFFFFF80, 5'd6, 1'b0, 2'd0});
      run_req("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 0, 1'b0, 32'h80000000,
              4'b1000, 32'h100, 32'h0, 1, '{32'h00000080, 5'd7, 1'b0, 2'd0});
      run_req("sh", 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 5'd9, 1, 1'b0, 32'h0,
              4'b1100, 32'h100, 32'hABCDABCD, 2, '{32'h0, 5'd0, 1'b0, 2'd0});
      run_req("lh", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd10, 0, 1'b0, 32'h80010000,
              4'b1100, 32'h100, 32'h0, 1, '{32'hFFFF8001, 5'd10, 1'b0, 2'd0});
      run_req("lhu", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 5'd11, 0, 1'b0, 32'h80010000,
              4'b1100, 32'h100, 32'h0, 1, '{32'h00008001, 5'd11, 1'b0, 2'd0});
      run_req("sb", 1'b1, 2'd0, 1'b0, 32'h101, 32'h000000A5, 5'd1, 0, 1'b0, 32'h0,
              4'b0010, 32'h100, 32'hA5A5A5A5, 1, '{32'h0, 5'd0, 1'b0, 2'd0});
      run_req("lw_rd0", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd0, 0, 1'b0, 32'h13579BDF,
              4'b1111, 32'h10, 32'h0, 1, '{32'h13579BDF, 5'd0, 1'b0, 2'd0});
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      run_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, -1, 1'b0, 32'h11223344,
              4'b0000, 32'h0, 32'h0, 0, '{32'h0, 5'd0, 1'b1, 2'd1});
      run_req("sd_32", 1'b1, 2'd3, 1'b0, 32'h300, 32'h01020304, 5'd2, -1, 1'b0, 32'h0,
              4'b0000, 32'h0, 32'h0, 0, '{32'h0, 5'd0, 1'b1, 2'd1});
`else
      run_req("lw_mis", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, 0, 1'b0, 32'h11223344,
              4'b1111, 32'h100, 32'h0, 1, '{32'h11223344, 5'd3, 1'b0, 2'd0});
      run_req("sd_32", 1'b1, 2'd3, 1'b0, 32'h300, 32'h01020304, 5'd2, 0, 1'b0, 32'h0,
              4'b1111, 32'h300, 32'h01020304, 1, '{32'h0, 5'd0, 1'b0, 2'd0});
`endif
      run_req("timeout", 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd12, -1, 1'b0, 32'h0,
              4'b1111, 32'h200, 32'h0, 4, '{32'h0, 5'd0, 1'b1, 2'd3});
      run_req("ack_last", 1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 5'd13, 3, 1'b0, 32'hCAFEF00D,
              4'b1111, 32'h204, 32'h0, 4, '{32'hCAFEF00D, 5'd13, 1'b0, 2'd0});
      run_req("bus_err", 1'b0, 2'd2, 1'b0, 32'h208, 32'h0, 5'd14, 0, 1'b1, 32'hFFFFFFFF,
              4'b1111, 32'h208, 32'h0, 1, '{32'h0, 5'd0, 1'b1, 2'd2});

      // Reset during ACCESS: access abandoned, no response
      @(posedge clk);
      #1;
      chk("rstacc_ready", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'd2;
      bus.req_addr  = 32'h400;
      bus.req_rd    = 5'd15;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rstacc_mem_req_before", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstacc_mem_req_after", 32'(bus.mem_req), 32'd0);
      chk("rstacc_ready_after", 32'(bus.req_ready), 32'd1);
      chk("rstacc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      repeat (6) @(negedge clk);
      chk("rstacc_idle_mem_req", 32'(bus.mem_req), 32'd0);

      run_req("after_rst", 1'b0, 2'd2, 1'b0, 32'h40C, 32'h0, 5'd16, 0, 1'b0, 32'h0BADF00D,
              4'b1111, 32'h40C, 32'h0, 1, '{32'h0BADF00D, 5'd16, 1'b0, 2'd0});

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
